// File: rtl/riscv_muldiv_pkg.sv
// Shared opcode and state encodings for the iterative M-extension unit.
package riscv_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/riscv_muldiv_if.sv
// Operand request and result response handshakes of the multiply/divide unit.
interface riscv_muldiv_if
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    md_op_e          op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/riscv_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module riscv_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              i_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_opnd,
    output logic [2*XLEN-1:0] o_acc
);
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_nx;

    always_comb begin
        // Multiply: {hi, multiplier} with the carry of hi+mcand shifted back in
        w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        // Divide: {remainder, dividend}, quotient bits enter at the bottom
        w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
        w_ge     = (w_rem_sh >= {1'b0, i_opnd});
        w_diff   = w_rem_sh[XLEN-1:0] - i_opnd;
        w_rem_nx = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
        if (i_div)
            o_acc = {w_rem_nx, i_acc[XLEN-2:0], w_ge};
        else
            o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit, one radix-2 step per cycle.
// Optional RISCV_MULDIV_EARLY_OUT_EN: 1-cycle finish for trivial divide/multiply.
module riscv_muldiv
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    riscv_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_result;
    logic              r_div, r_hi, r_rem, r_neg, r_out_valid;

    logic              w_div, w_sa, w_sb, w_special;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_res, w_fin, w_q, w_r;
    logic [2*XLEN-1:0] w_step, w_prod;

    riscv_muldiv_step #(.XLEN(XLEN)) u_step (
        .i_div  (r_div),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_step)
    );

    always_comb begin
        w_div   = bus.op[2];
        w_sa    = bus.a[XLEN-1] & (bus.op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
        w_sb    = bus.b[XLEN-1] & (bus.op inside {MD_MULH, MD_DIV, MD_REM});
        w_mag_a = w_sa ? -bus.a : bus.a;
        w_mag_b = w_sb ? -bus.b : bus.b;
        w_special  = 1'b0;
        w_spec_res = '0;
        if (w_div && bus.b == '0) begin
            w_special  = 1'b1;
            w_spec_res = bus.op[1] ? bus.a : '1;
        end else if ((bus.op == MD_DIV || bus.op == MD_REM) && bus.a == SMIN && bus.b == '1) begin
            w_special  = 1'b1;
            w_spec_res = bus.op[1] ? '0 : bus.a;
        end
`ifdef RISCV_MULDIV_EARLY_OUT_EN
        else if (w_div && w_mag_a < w_mag_b) begin
            w_special  = 1'b1;
            w_spec_res = bus.op[1] ? bus.a : '0;
        end else if (!w_div && (bus.a == '0 || bus.b == '0)) begin
            w_special  = 1'b1;
            w_spec_res = '0;
        end
`endif
    end

    // Sign correction is applied to the output of the final iteration
    always_comb begin
        w_prod = r_neg ? -w_step : w_step;
        w_q    = w_step[XLEN-1:0];
        w_r    = w_step[2*XLEN-1:XLEN];
        if (r_div)
            w_fin = r_rem ? (r_neg ? -w_r : w_r) : (r_neg ? -w_q : w_q);
        else
            w_fin = r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= MD_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_result    <= '0;
            r_div       <= 1'b0;
            r_hi        <= 1'b0;
            r_rem       <= 1'b0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= MD_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (bus.in_valid) begin
                        r_div  <= w_div;
                        r_hi   <= (bus.op != MD_MUL);
                        r_rem  <= bus.op[1];
                        // Remainder takes the dividend sign only
                        r_neg  <= w_sa ^ (w_sb & ~(w_div & bus.op[1]));
                        r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                        r_opnd <= w_mag_b;
                        if (w_special) begin
                            r_result    <= w_spec_res;
                            r_out_valid <= 1'b1;
                            r_state     <= MD_DONE;
                        end else begin
                            r_cnt   <= CNT_W'(XLEN);
                            r_state <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_result    <= w_fin;
                        r_out_valid <= 1'b1;
                        r_state     <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= MD_IDLE;
                    end
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == MD_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed and random checks of riscv_muldiv against an arithmetic reference.
module tb_riscv_muldiv;
    import riscv_muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [XLEN-1:0] sb_q[$];

    riscv_muldiv_if #(.XLEN(XLEN)) bus ();

    riscv_muldiv #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_md(input md_op_e op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        longint          sa, sb, sp;
        longint unsigned up;
        logic            ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MD_MUL:    begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            MD_MULH:   begin sp = sa * sb; return sp[63:32]; end
            MD_MULHSU: begin sp = sa * longint'({32'd0, b}); return sp[63:32]; end
            MD_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            MD_DIV:    return (b == 0) ? '1 : ovf ? a : XLEN'(int'(a) / int'(b));
            MD_DIVU:   return (b == 0) ? '1 : a / b;
            MD_REM:    return (b == 0) ? a : ovf ? '0 : XLEN'(int'(a) % int'(b));
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input md_op_e op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == '1) return 1;
        return LAT;
    endfunction

    // Present one request at a negedge; returns just after the accepting edge
    task automatic issue(input md_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("issue_ready", 64'(bus.in_ready), 64'd1);
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.op = md_op_e'($urandom_range(0, 7));
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int          lat = 1;
        logic        busy = 1'b0;
        logic [31:0] exp;
        @(negedge clk);
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) busy = 1'b1;
            lat++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, 64'(busy | bus.in_ready), 64'd0);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_res"}, 64'(bus.result), 64'(exp));
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input string tag, input md_op_e op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
        sb_q.push_back(exp);
        issue(op, a, b);
        wait_result(tag, ref_lat(op, a, b));
    endtask

    task automatic no_output(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [XLEN-1:0] ra, rb, held;
        md_op_e          rop;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = MD_MUL; bus.a = '0; bus.b = '0;
        #2;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run("mul", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run("mulh", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run("mulhu", MD_MULHU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run("rem_neg", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run("divu", MD_DIVU, 32'd100, 32'd7, 32'd14);
        run("remu", MD_REMU, 32'd100, 32'd7, 32'd2);
        run("divu_z", MD_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run("rem_z", MD_REM, 32'd100, 32'd0, 32'd100);
        run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Backpressure: result held for 5 cycles while out_ready is low
        bus.out_ready = 1'b0;
        sb_q.push_back(32'd14);
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_result("bp", LAT);
        held = 32'd14;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold", 64'(bus.result), 64'(held));
            check("bp_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_drop", 64'(bus.out_valid), 64'd0);
        check("bp_idle", 64'(bus.in_ready), 64'd1);

        // Flush mid-calculation
        issue(MD_MUL, 32'd123, 32'd456);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", 64'(bus.in_ready), 64'd1);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        no_output("flush_quiet", 40);

        // Flush wins over a request presented in IDLE
        @(negedge clk);
        bus.op = MD_DIVU; bus.a = 32'd5; bus.b = 32'd0; bus.in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_req", 64'(bus.in_ready), 64'd1);
        no_output("flush_req_quiet", 10);

        // Asynchronous reset mid-calculation
        issue(MD_DIVU, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(bus.in_ready), 64'd1);
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("divu_after", MD_DIVU, 32'd9, 32'd3, 32'd3);

        for (int i = 0; i < 16; i++) begin
            rop = md_op_e'(i % 8);
            ra  = $urandom;
            rb  = (i % 5 == 4) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            if (i % 7 == 6) ra = -ra;
            run($sformatf("rnd%0d", i), rop, ra, rb, ref_md(rop, ra, rb));
        end

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/riscv_muldiv.md
Name: riscv_muldiv

Overview:
Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations; it is the sequential companion to the single-cycle ALU.
- Operands come from the execute stage over a valid/ready handshake.
- The result returns over a second valid/ready handshake.
- The core stalls issue while the unit is busy.

Parameters:
XLEN, 32, operand/result width; any even value >= 8
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of any operation in flight
in_valid  in  1  operands/opcode valid
in_ready  out  1  unit can accept (high only in IDLE)
op  in  3  M opcode: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
a  in  XLEN  rs1 operand
b  in  XLEN  rs2 operand
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  result data

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, result=0, counter=0, internal registers=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_valid&in_ready latches op, a, b.
  - Signed ops (MULH/MULHSU a only, DIV/REM) convert to magnitudes and record result sign.
  - Normal operations go to CALC with counter=XLEN.
  - Special cases go directly to DONE.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; counter decrements.
  - When counter reaches 1, the next edge applies sign correction and goes to DONE.
  - Total latency: acceptance edge + XLEN edges, so out_valid rises XLEN+1 cycles after acceptance.
- DONE:
  - out_valid=1; result is held stable until out_valid&out_ready, then the unit returns to IDLE.
  - The next op may be accepted no earlier than the cycle after the return (no same-cycle re-accept).
- Multiply width rules:
  - Product is 2*XLEN bits.
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits.
  - MULHSU treats b as unsigned.
- Division special cases (1-cycle, out_valid at the cycle after acceptance):
  - b==0: DIV/DIVU quotient = all ones; REM/REMU = a.
  - Signed overflow (a==-2^(XLEN-1), b==-1): DIV = a; REM = 0.
- Remainder sign follows the dividend; quotient rounds toward zero.
- flush:
  - Any state goes to IDLE next edge; out_valid drops; no result is delivered.
  - flush with in_valid in IDLE: the request is not accepted.
  - flush has priority over out_ready and in_valid.
- Inputs a/b/op are ignored outside IDLE.
- rst_n asserted mid-CALC: immediate return to the reset values above.

Optional Feature:
Macro RISCV_MULDIV_EARLY_OUT_EN.
- Defined:
  - Divide operations whose dividend magnitude < divisor magnitude finish in 1 cycle (quotient 0, remainder a).
  - Multiply with either operand zero finishes in 1 cycle with result 0.
  - All other timing is unchanged.
- Undefined: only the division-special cases above take the short path; everything else takes XLEN+1 cycles.

Decomposition:
- Shared defs include: MD_MUL..MD_REMU 3-bit opcode macros (values equal to RISC-V funct3 0..7) and state encodings MD_IDLE/MD_CALC/MD_DONE.
- One natural sub-module: riscv_muldiv_step, a combinational single radix-2 iteration (mode, partial accumulator, operand in, next accumulator out), instantiated once.
- Controller, counter and sign handling stay in riscv_muldiv.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), out_ready=1 -> result 0xFFFFFFEB, out_valid exactly 33 cycles after acceptance; in_ready low throughout.
- MULH a=b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- REM a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFF; DIV same operands -> 0xFFFFFFFD; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 100/0 -> 0xFFFFFFFF; REM 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; all with out_valid one cycle after acceptance.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0; the out_ready pulse returns the unit to IDLE next cycle.
- Abort: flush at CALC cycle 10 -> IDLE next edge, no out_valid. rst_n low at CALC cycle 5 -> outputs at reset values immediately. The following DIVU 9/3 completes normally with result 3.
